// File: rtl/sp_scan_sequencer_pkg.sv
// Shared definitions for the solar-panel sweep controller:
// FSM state encoding (doubles as the stat code), axis select and ADC widths.
package sp_pkg;

  localparam int unsigned ADC_W = 12;
  // Four-sample accumulator width used when averaging is enabled.
  localparam int unsigned ACC_W = ADC_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_PARK    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_e;

endpackage

// File: rtl/sp_scan_sequencer_if.sv
// ADC sample handshake: the sequencer (master) raises adc_req and holds it
// until the converter (slave) returns a one-cycle adc_valid with adc_data.
interface sp_scan_sequencer_if;
  import sp_pkg::*;

  logic             adc_req;
  logic             adc_valid;
  logic [ADC_W-1:0] adc_data;

  modport master (
    output adc_req,
    input  adc_valid,
    input  adc_data
  );

  modport slave (
    input  adc_req,
    output adc_valid,
    output adc_data
  );

endinterface

// File: rtl/sp_scan_sequencer_settle_timer.sv
// Servo settle timer: load on SETTLE entry, count down while running,
// expired_o high once SETTLE_CYC cycles of SETTLE have elapsed.
module sp_settle_timer #(
  parameter int unsigned SETTLE_CYC = 1000000,
  parameter int unsigned SETTLE_W   = 20
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE_CYC - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // Next count: reload on entry, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sp_scan_sequencer.sv
// Sweep controller: steps the H servo across its range, samples panel voltage
// per position, parks at the best one, then repeats on the V axis.
// Manual push-button stepping is accepted while idle or done.
// Optional feature macro: SP_SCAN_AVG_EN (average four ADC samples per position).
module sp_scan_sequencer
  import sp_pkg::*;
#(
  parameter int unsigned POS_W      = 8,
  parameter int unsigned POS_MAX    = 180,
  parameter int unsigned POS_STEP   = 5,
  parameter int unsigned SETTLE_CYC = 1000000,
  parameter int unsigned SETTLE_W   = 20
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                abort,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic                btn_u,
  input  logic                btn_d,
  sp_scan_sequencer_if.master adc,
  output logic [POS_W-1:0]    pos_h,
  output logic [POS_W-1:0]    pos_v,
  output logic [ADC_W-1:0]    max_v,
  output logic                busy,
  output logic                done,
  output logic [2:0]          stat
);

  localparam logic [POS_W:0]   STEP_X    = (POS_W+1)'(POS_STEP);
  localparam logic [POS_W:0]   MAX_X     = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W-1:0] POS_RESET = POS_W'(POS_MAX / 2);

  state_e           state_q, state_d;
  axis_e            axis_q, axis_d;
  logic [POS_W-1:0] pos_h_q, pos_h_d;
  logic [POS_W-1:0] pos_v_q, pos_v_d;
  logic [ADC_W-1:0] max_v_q, max_v_d;
  logic [POS_W-1:0] best_q, best_d;
  logic [ADC_W-1:0] sample_q, sample_d;
  logic             adc_req_q, adc_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [POS_W-1:0] cur_pos;
  logic [POS_W:0]   nxt_pos;
  logic             sweeping;
  logic             settle_load;
  logic             settle_expired;

`ifdef SP_SCAN_AVG_EN
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       avg_cnt_q, avg_cnt_d;
  logic [ACC_W-1:0] acc_sum;
`endif

  // Saturating manual step; opposing buttons cancel.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                 input logic up,
                                                 input logic dn);
    logic [POS_W:0] s;
    s = {1'b0, p} + STEP_X;
    if (up && !dn) begin
      return (s > MAX_X) ? MAX_X[POS_W-1:0] : s[POS_W-1:0];
    end
    if (dn && !up) begin
      return ({1'b0, p} < STEP_X) ? '0 : p - STEP_X[POS_W-1:0];
    end
    return p;
  endfunction

  sp_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC),
    .SETTLE_W   (SETTLE_W)
  ) u_settle (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load_i    (settle_load),
    .run_i     (state_q == ST_SETTLE),
    .expired_o (settle_expired)
  );

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    pos_h_d   = pos_h_q;
    pos_v_d   = pos_v_q;
    max_v_d   = max_v_q;
    best_d    = best_q;
    sample_d  = sample_q;
    adc_req_d = adc_req_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef SP_SCAN_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + ACC_W'(adc.adc_data);
`endif
    cur_pos  = (axis_q == AXIS_V) ? pos_v_q : pos_h_q;
    nxt_pos  = {1'b0, cur_pos} + STEP_X;
    sweeping = (state_q != ST_IDLE) && (state_q != ST_DONE);

    if (abort && sweeping) begin
      state_d   = ST_IDLE;
      adc_req_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
`ifdef SP_SCAN_AVG_EN
      acc_d     = '0;
      avg_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_SETTLE;
            axis_d  = AXIS_H;
            pos_h_d = '0;
            max_v_d = '0;
            best_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
`ifdef SP_SCAN_AVG_EN
            acc_d     = '0;
            avg_cnt_d = '0;
`endif
          end else begin
            pos_h_d = step_pos(pos_h_q, btn_r, btn_l);
            pos_v_d = step_pos(pos_v_q, btn_u, btn_d);
          end
        end
        ST_SETTLE: begin
          if (settle_expired) begin
            state_d   = ST_SAMPLE;
            adc_req_d = 1'b1;
          end
        end
        ST_SAMPLE: begin
`ifdef SP_SCAN_AVG_EN
          // Request is dropped for one cycle after each strobe, then re-raised
          // until the fourth sample closes the average.
          if (adc.adc_valid && adc_req_q) begin
            adc_req_d = 1'b0;
            if (avg_cnt_q == 2'd3) begin
              sample_d  = acc_sum[ADC_W+1:2];
              acc_d     = '0;
              avg_cnt_d = '0;
              state_d   = ST_COMPARE;
            end else begin
              acc_d     = acc_sum;
              avg_cnt_d = avg_cnt_q + 2'd1;
            end
          end else if (!adc_req_q) begin
            adc_req_d = 1'b1;
          end
`else
          if (adc.adc_valid && adc_req_q) begin
            sample_d  = adc.adc_data;
            adc_req_d = 1'b0;
            state_d   = ST_COMPARE;
          end
`endif
        end
        ST_COMPARE: begin
          if (sample_q > max_v_q) begin
            max_v_d = sample_q;
            best_d  = cur_pos;
          end
          if (nxt_pos <= MAX_X) begin
            if (axis_q == AXIS_V) begin
              pos_v_d = nxt_pos[POS_W-1:0];
            end else begin
              pos_h_d = nxt_pos[POS_W-1:0];
            end
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_PARK;
          end
        end
        ST_PARK: begin
          if (axis_q == AXIS_H) begin
            pos_h_d = best_q;
            axis_d  = AXIS_V;
            pos_v_d = '0;
            max_v_d = '0;
            best_d  = '0;
            state_d = ST_SETTLE;
          end else begin
            pos_v_d = best_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      axis_q    <= AXIS_H;
      pos_h_q   <= POS_RESET;
      pos_v_q   <= POS_RESET;
      max_v_q   <= '0;
      best_q    <= '0;
      sample_q  <= '0;
      adc_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      axis_q    <= axis_d;
      pos_h_q   <= pos_h_d;
      pos_v_q   <= pos_v_d;
      max_v_q   <= max_v_d;
      best_q    <= best_d;
      sample_q  <= sample_d;
      adc_req_q <= adc_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SP_SCAN_AVG_EN
  // Averaging accumulator registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`endif

  assign adc.adc_req = adc_req_q;
  assign pos_h       = pos_h_q;
  assign pos_v       = pos_v_q;
  assign max_v       = max_v_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stat        = state_q;

endmodule
